// File: rtl/ibex_rf_preload_ctrl.sv
// Bulk-loads a contiguous run of GPRs through the regfile side write port, optionally halting the core first.
// One side write per accepted source beat, presented the cycle after acceptance; writes lost to a same-address core write are retried.
module ibex_rf_preload_ctrl #(
    parameter bit          RV32E       = 1'b0,
    parameter int unsigned DataWidth   = 32,
    parameter bit          RequireHalt = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [4:0]           base_addr_i,
    input  logic [5:0]           count_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [7:0]           coll_cnt_o,
    input  logic                 src_valid_i,
    input  logic [DataWidth-1:0] src_data_i,
    output logic                 src_ready_o,
    output logic                 halt_req_o,
    input  logic                 halt_ack_i,
    input  logic                 core_we_i,
    input  logic [4:0]           core_waddr_i,
    output logic                 rf_input_valid_o,
    output logic [4:0]           rf_input_addr_o,
    output logic [DataWidth-1:0] rf_input_data_o
);

    localparam logic [5:0] NumWords = RV32E ? 6'd16 : 6'd32;
    localparam logic [4:0] LastAddr = 5'(NumWords - 6'd1);

    typedef enum logic [1:0] {
        IDLE,
        HALT,
        LOAD,
        DONE
    } state_e;

    state_e               state_q;
    logic [4:0]           cur_addr_q;
    logic [5:0]           beats_left_q;
    logic                 out_vld_q;
    logic [4:0]           out_addr_q;
    logic [DataWidth-1:0] out_data_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic                 halt_req_q;
    logic [7:0]           coll_cnt_q;

    logic start_bad;
    logic coll;
    logic accept;
    logic wr_done;

    assign start_bad = (base_addr_i == 5'd0) || ({1'b0, base_addr_i} >= NumWords) ||
                       (count_i == 6'd0) || (count_i > (NumWords - 6'd1));

    // The core write wins inside the regfile, so a same-address core write means our write was lost.
    assign coll    = out_vld_q && core_we_i && (core_waddr_i == out_addr_q);
    assign wr_done = out_vld_q && !coll;

    // coll implies out_vld_q, so !coll alone covers "empty or draining".
    assign src_ready_o = (state_q == LOAD) && (beats_left_q != 6'd0) && !coll;
    assign accept      = src_valid_i && src_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cur_addr_q   <= 5'd0;
            beats_left_q <= 6'd0;
            out_vld_q    <= 1'b0;
            out_addr_q   <= 5'd0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            halt_req_q   <= 1'b0;
            coll_cnt_q   <= 8'd0;
        end else begin
            err_q <= 1'b0;

            if (coll && (coll_cnt_q != 8'hFF)) begin
                coll_cnt_q <= coll_cnt_q + 8'd1;
            end

            // A new beat may replace a completing write in the same cycle; on collision everything holds.
            if (accept) begin
                out_vld_q    <= 1'b1;
                out_addr_q   <= cur_addr_q;
                out_data_q   <= src_data_i;
                cur_addr_q   <= (cur_addr_q == LastAddr) ? 5'd1 : cur_addr_q + 5'd1;
                beats_left_q <= beats_left_q - 6'd1;
            end else if (wr_done) begin
                out_vld_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (start_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            cur_addr_q   <= base_addr_i;
                            beats_left_q <= count_i;
                            coll_cnt_q   <= 8'd0;
                            busy_q       <= 1'b1;
                            halt_req_q   <= RequireHalt;
                            state_q      <= RequireHalt ? HALT : LOAD;
                        end
                    end
                end
                HALT: begin
                    if (halt_ack_i) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if ((beats_left_q == 6'd0) && wr_done) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    halt_req_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign halt_req_o       = halt_req_q;
    assign coll_cnt_o       = coll_cnt_q;
    assign rf_input_valid_o = out_vld_q;
    assign rf_input_addr_o  = out_addr_q;
    assign rf_input_data_o  = out_data_q;

endmodule

// File: tb/tb_ibex_rf_preload_ctrl.sv
// Scoreboard bench for ibex_rf_preload_ctrl: dut0 is RV32I with halt handshake, dut1 is RV32E loading immediately.
module tb_ibex_rf_preload_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start[2];
    logic [4:0]  base[2];
    logic [5:0]  cnt[2];
    logic        src_v[2];
    logic [31:0] src_d[2];
    logic        halt_ack[2];
    logic        core_we[2];
    logic [4:0]  core_wa[2];
    logic        busy[2], done[2], err[2], src_rdy[2], halt_req[2], rf_v[2];
    logic [7:0]  coll_cnt[2];
    logic [4:0]  rf_a[2];
    logic [31:0] rf_d[2];

    ibex_rf_preload_ctrl #(.RV32E(1'b0), .DataWidth(32), .RequireHalt(1'b1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .base_addr_i(base[0]), .count_i(cnt[0]),
        .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .coll_cnt_o(coll_cnt[0]),
        .src_valid_i(src_v[0]), .src_data_i(src_d[0]), .src_ready_o(src_rdy[0]),
        .halt_req_o(halt_req[0]), .halt_ack_i(halt_ack[0]),
        .core_we_i(core_we[0]), .core_waddr_i(core_wa[0]),
        .rf_input_valid_o(rf_v[0]), .rf_input_addr_o(rf_a[0]), .rf_input_data_o(rf_d[0])
    );

    ibex_rf_preload_ctrl #(.RV32E(1'b1), .DataWidth(32), .RequireHalt(1'b0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .base_addr_i(base[1]), .count_i(cnt[1]),
        .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .coll_cnt_o(coll_cnt[1]),
        .src_valid_i(src_v[1]), .src_data_i(src_d[1]), .src_ready_o(src_rdy[1]),
        .halt_req_o(halt_req[1]), .halt_ack_i(halt_ack[1]),
        .core_we_i(core_we[1]), .core_waddr_i(core_wa[1]),
        .rf_input_valid_o(rf_v[1]), .rf_input_addr_o(rf_a[1]), .rf_input_data_o(rf_d[1])
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] srcq0[$], srcq1[$];
    logic [36:0] expq0[$], expq1[$];
    bit          stall_en[2], coll_en[2], hs[2], retry_pend[2], busy_seen[2];
    bit          ack_given;
    int          coll_model[2], done_cnt[2], err_cnt[2];
    logic [4:0]  ret_a[2];
    logic [31:0] ret_d[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int src_size(input int d);
        return (d == 0) ? srcq0.size() : srcq1.size();
    endfunction

    function automatic logic [31:0] src_front(input int d);
        return (d == 0) ? srcq0[0] : srcq1[0];
    endfunction

    function automatic int exp_size(input int d);
        return (d == 0) ? expq0.size() : expq1.size();
    endfunction

    task automatic src_push(input int d, input logic [31:0] v);
        if (d == 0) srcq0.push_back(v); else srcq1.push_back(v);
    endtask

    task automatic src_pop(input int d);
        if (d == 0) void'(srcq0.pop_front()); else void'(srcq1.pop_front());
    endtask

    task automatic exp_push(input int d, input logic [36:0] v);
        if (d == 0) expq0.push_back(v); else expq1.push_back(v);
    endtask

    task automatic exp_pop(input int d, output logic [36:0] v);
        if (d == 0) v = expq0.pop_front(); else v = expq1.pop_front();
    endtask

    // Source and core-port stimulus; handshake decided once inputs have settled mid-cycle.
    task automatic drive(input int d);
        forever begin
            @(negedge clk);
            if (hs[d] && src_size(d) > 0) src_pop(d);
            src_v[d]   = (src_size(d) > 0) && (!stall_en[d] || $urandom_range(3) != 0);
            src_d[d]   = (src_size(d) > 0) ? src_front(d) : 32'h0;
            core_we[d] = 1'b0;
            core_wa[d] = 5'd0;
            if (coll_en[d]) begin
                case ($urandom_range(3))
                    0: begin core_we[d] = 1'b1; core_wa[d] = rf_a[d]; end
                    1: begin core_we[d] = 1'b1; core_wa[d] = 5'($urandom_range(31)); end
                    default: ;
                endcase
            end
            #1;
            hs[d] = src_v[d] && src_rdy[d];
        end
    endtask

    task automatic monitor(input int d);
        logic [36:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (busy[d]) busy_seen[d] = 1'b1;
                if (done[d]) done_cnt[d]++;
                if (err[d])  err_cnt[d]++;
                if (retry_pend[d]) begin
                    chk("retry_vld", rf_v[d], 1'b1);
                    chk("retry_addr", rf_a[d], ret_a[d]);
                    chk("retry_data", rf_d[d], ret_d[d]);
                    retry_pend[d] = 1'b0;
                end
                if (rf_v[d]) begin
                    if (d == 0) chk("ack_before_write", ack_given, 1'b1);
                    if (core_we[d] && core_wa[d] == rf_a[d]) begin
                        coll_model[d] = (coll_model[d] < 255) ? coll_model[d] + 1 : 255;
                        retry_pend[d] = 1'b1;
                        ret_a[d]      = rf_a[d];
                        ret_d[d]      = rf_d[d];
                    end else if (exp_size(d) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write dut%0d: got addr %0d data %0h, expected no write", d, rf_a[d], rf_d[d]);
                    end else begin
                        exp_pop(d, e);
                        chk("write_addr", rf_a[d], e[36:32]);
                        chk("write_data", rf_d[d], e[31:0]);
                    end
                end
            end
        end
    endtask

    task automatic run_load(input int d, input int b, input int n, input int ack_dly,
                            input bit stall, input bit coll, input bit busy_start);
        int nw, a, c, exp_c;
        logic [31:0] v;
        nw = (d == 0) ? 32 : 16;
        stall_en[d] = stall;
        coll_en[d]  = coll;
        a = b;
        for (int i = 0; i < n; i++) begin
            v = $urandom;
            src_push(d, v);
            exp_push(d, {5'(a), v});
            a = (a == nw - 1) ? 1 : a + 1;
        end
        coll_model[d] = 0;
        done_cnt[d]   = 0;
        err_cnt[d]    = 0;
        @(negedge clk);
        start[d] = 1'b1;
        base[d]  = 5'(b);
        cnt[d]   = 6'(n);
        c = 0;
        do begin
            @(negedge clk);
            c++;
            start[d] = busy_start && (c == 3);
            if (d == 0 && c == 1 + ack_dly) begin
                halt_ack[0] = 1'b1;
                ack_given   = 1'b1;
            end
        end while (!done[d] && c < 1000);
        if (!done[d]) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dut%0d: no done_o after %0d cycles", d, c);
        end
        #3;
        chk("done_coll_cnt", coll_cnt[d], coll_model[d]);
        chk("halt_req_in_done", halt_req[d], (d == 0));
        if (!stall && !coll) begin
            exp_c = (d == 0) ? n + 3 + ack_dly : n + 2;
            chk("done_cycle", c, exp_c);
        end
        @(negedge clk);
        start[d] = 1'b0;
        #3;
        chk("idle_busy", busy[d], 1'b0);
        chk("idle_halt_req", halt_req[d], 1'b0);
        chk("done_pulses", done_cnt[d], 1);
        chk("busy_start_no_err", err_cnt[d], 0);
        chk("all_written", exp_size(d), 0);
        halt_ack[0] = 1'b0;
        ack_given   = 1'b0;
        stall_en[d] = 1'b0;
        coll_en[d]  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic bad_start(input int d, input int b, input int n, input string name);
        err_cnt[d]   = 0;
        busy_seen[d] = 1'b0;
        @(negedge clk);
        start[d] = 1'b1;
        base[d]  = 5'(b);
        cnt[d]   = 6'(n);
        @(negedge clk);
        start[d] = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk({name, "_err_pulse"}, err_cnt[d], 1);
        chk({name, "_busy"}, busy_seen[d], 1'b0);
    endtask

    task automatic check_zero(input int d, input string name);
        chk({name, "_busy"}, busy[d], 1'b0);
        chk({name, "_done"}, done[d], 1'b0);
        chk({name, "_err"}, err[d], 1'b0);
        chk({name, "_coll_cnt"}, coll_cnt[d], 8'd0);
        chk({name, "_src_rdy"}, src_rdy[d], 1'b0);
        chk({name, "_halt_req"}, halt_req[d], 1'b0);
        chk({name, "_rf_vld"}, rf_v[d], 1'b0);
        chk({name, "_rf_addr"}, rf_a[d], 5'd0);
        chk({name, "_rf_data"}, rf_d[d], 32'd0);
    endtask

    task automatic main_seq();
        int d, nw;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; base[i] = 5'd0; cnt[i] = 6'd0; halt_ack[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        rst_n = 1'b1;
        @(negedge clk);

        run_load(1, 5, 3, 0, 1'b0, 1'b0, 1'b0);
        run_load(0, 30, 4, 0, 1'b0, 1'b0, 1'b0);
        run_load(1, 14, 3, 0, 1'b0, 1'b0, 1'b0);
        run_load(0, 5, 3, 4, 1'b0, 1'b0, 1'b0);
        run_load(1, 6, 8, 0, 1'b0, 1'b1, 1'b0);
        run_load(0, 2, 6, 1, 1'b0, 1'b0, 1'b1);

        bad_start(0, 0, 3, "base0");
        bad_start(0, 5, 0, "count0");
        bad_start(0, 1, 32, "count32");
        bad_start(1, 16, 2, "base16_rv32e");
        bad_start(1, 1, 16, "count16_rv32e");

        for (int i = 0; i < 30; i++) begin
            d  = i % 2;
            nw = (d == 0) ? 32 : 16;
            run_load(d, $urandom_range(nw - 1, 1), $urandom_range(nw - 1, 1), $urandom_range(5),
                     1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
        end

        // Abort a 5-word load on dut1 after its second write.
        src_push(1, 32'h1111_0001); src_push(1, 32'h1111_0002); src_push(1, 32'h1111_0003);
        src_push(1, 32'h1111_0004); src_push(1, 32'h1111_0005);
        exp_push(1, {5'd3, 32'h1111_0001});
        exp_push(1, {5'd4, 32'h1111_0002});
        @(negedge clk);
        start[1] = 1'b1; base[1] = 5'd3; cnt[1] = 6'd5;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check_zero(1, "abort");
        chk("abort_writes_seen", exp_size(1), 0);
        srcq1.delete();
        expq1.delete();
        hs[1]         = 1'b0;
        retry_pend[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n        = 1'b1;
        busy_seen[1] = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        chk("post_abort_busy", busy_seen[1], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    initial begin
        fork
            drive(0);
            drive(1);
            monitor(0);
            monitor(1);
            main_seq();
        join
    end

endmodule

// File: doc/ibex_rf_preload_ctrl.md
# ibex_rf_preload_ctrl

Sequencer that bulk-loads a contiguous run of general-purpose registers through the register file's side-channel write port (`input_valid`/`input_addr`/`input_data`). It sits between a debug/test data source (valid/ready stream) and the register file. It optionally halts the core before writing. It snoops the core write port and re-issues any side write lost to a same-address core write, because the core write has priority inside the register file.

## Interface
- `RV32E`, default 0: 1 limits the register space to x1..x15 (NUM_WORDS=16); 0 gives x1..x31 (NUM_WORDS=32).
- `DataWidth`, default 32: register data width.
- `RequireHalt`, default 1: 1 requests and waits for a core halt before loading; 0 loads immediately.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `start_i`, in, 1: one-cycle load request; sampled only in IDLE.
- `base_addr_i`, in, 5: first destination register.
- `count_i`, in, 6: number of registers to write.
- `busy_o`, out, 1: high in every state except IDLE.
- `done_o`, out, 1: one-cycle pulse when a load completes.
- `err_o`, out, 1: one-cycle pulse when a start is rejected.
- `coll_cnt_o`, out, 8: saturating count of retried writes; cleared on accepted start.
- `src_valid_i`, in, 1: source data valid.
- `src_data_i`, in, DataWidth: source data.
- `src_ready_o`, out, 1: a beat is accepted when valid && ready.
- `halt_req_o`, out, 1: request to the core to halt.
- `halt_ack_i`, in, 1: core is halted.
- `core_we_i`, in, 1: snooped core regfile write enable.
- `core_waddr_i`, in, 5: snooped core write address.
- `rf_input_valid_o`, out, 1: side write strobe.
- `rf_input_addr_o`, out, 5: side write address.
- `rf_input_data_o`, out, DataWidth: side write data.

## Operation
- States: IDLE, HALT, LOAD, DONE.
- IDLE + `start_i`:
  - Reject if `base_addr_i`==0, `base_addr_i`>=NUM_WORDS, `count_i`==0 or `count_i`>NUM_WORDS-1. Pulse `err_o`, stay IDLE.
  - Otherwise latch base and count, clear `coll_cnt_o`, and go to HALT (RequireHalt=1) or LOAD (RequireHalt=0).
- HALT: assert `halt_req_o`. Go to LOAD on the first cycle `halt_ack_i`=1.
- `halt_req_o` stays high through LOAD and DONE. `halt_ack_i` is ignored outside HALT.
- LOAD, accept side:
  - `src_ready_o` = LOAD && beats_left>0 && (!out_vld || !coll).
  - Each accepted beat loads the output register: valid=1, addr=cur_addr, data=src_data_i.
  - Then cur_addr advances and beats_left decrements.
- LOAD, address step: cur_addr+1, wrapping NUM_WORDS-1 -> 1. x0 is never targeted.
- Collision: coll = out_vld && `core_we_i` && `core_waddr_i`==`rf_input_addr_o`.
  - On collision the write is lost. Hold valid/addr/data unchanged for the next cycle (retry) and increment `coll_cnt_o`, saturating at 255.
  - A core write to a different address is not a collision.
- Write completion: out_vld && !coll. The output register clears unless a new beat is accepted in the same cycle, which gives back-to-back throughput of 1 beat/cycle.
- LOAD -> DONE when beats_left==0 and the final write completes.
- DONE lasts one cycle: `done_o`=1, `halt_req_o` deasserts on exit, then IDLE.
- `start_i` outside IDLE is ignored. No `err_o` is raised.

## Timing
- Reset values: all outputs 0, state IDLE, `coll_cnt_o`=0.
- Reset mid-operation aborts immediately. No further `rf_input_valid_o` is issued.
- A side write is presented the cycle after beat acceptance. The register file captures it at the end of that cycle.
- RequireHalt=0, no collisions, source always valid:
  - start at cycle 0, LOAD at cycle 1, first write at cycle 2.
  - Last of N writes at cycle N+1, `done_o` at cycle N+2, IDLE at cycle N+3.
- RequireHalt=1 adds the cycles spent waiting for `halt_ack_i`. LOAD is entered the cycle after ack is sampled.
- Source stall (`src_valid_i`=0) inserts bubbles. `rf_input_valid_o` drops to 0 while empty.

## Test plan
- RequireHalt=0, base=5, count=3, data 0xA,0xB,0xC streamed continuously -> writes x5,x6,x7 on cycles 2,3,4; `done_o` cycle 5; `coll_cnt_o`=0.
- base=30, count=4 (RV32E=0) -> writes to x30,x31,x1,x2. RV32E=1 with base=14, count=3 -> writes x14,x15,x1.
- Core write to x6 in the same cycle as side write x6 -> x6 re-issued next cycle with the same data; `coll_cnt_o`=1. A core write to x9 in that cycle causes no retry.
- Invalid starts: base=0, count=0, count=32 (RV32E=0), base=16 (RV32E=1) -> `err_o` pulse, `busy_o` stays 0, no side write. A start while busy -> ignored.
- RequireHalt=1, `halt_ack_i` after 4 cycles -> no side write before ack. `halt_req_o` high until the cycle after `done_o`.
- Assert `rst_ni` low mid-load after 2 of 5 writes -> all outputs 0 immediately. After release: IDLE, no writes.
